// File: rtl/shift_pkg.sv
// Shared types for the multi-cycle shift unit: operation modes and FSM states.
// Optional carry output is controlled by SHIFT_CARRY_EN in the files that use this package.
package shift_pkg;

  typedef enum logic [1:0] {
    SLL = 2'b00,
    SRL = 2'b01,
    SRA = 2'b10,
    ROL = 2'b11
  } shift_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } shift_state_t;

  // Modes that move bits toward the MSB lose bit WIDTH-1 on each step.
  function automatic logic is_left(input shift_mode_t mode);
    return (mode == SLL) || (mode == ROL);
  endfunction

endpackage

// File: rtl/seq_shifter_if.sv
// Start/Busy/Done handshake and operand bus between the controller and seq_shifter.
// carry_out is present only when SHIFT_CARRY_EN is defined.
interface seq_shifter_if
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
);

  localparam int SHW = $clog2(WIDTH);

  logic             start;
  logic [WIDTH-1:0] source;
  shift_mode_t      mode;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;
`ifdef SHIFT_CARRY_EN
  logic             carry_out;
`endif

`ifdef SHIFT_CARRY_EN
  modport master (output start, source, mode, shamt,
                  input  result, done, busy, carry_out);
  modport slave  (input  start, source, mode, shamt,
                  output result, done, busy, carry_out);
`else
  modport master (output start, source, mode, shamt,
                  input  result, done, busy);
  modport slave  (input  start, source, mode, shamt,
                  output result, done, busy);
`endif

endinterface

// File: rtl/shift_step.sv
// Combinational single-position shift of a WIDTH-bit word in one of four modes.
// The outgoing-bit output exists only when SHIFT_CARRY_EN is defined.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] word,
  input  shift_mode_t      mode,
  output logic [WIDTH-1:0] next_word
`ifdef SHIFT_CARRY_EN
  ,
  output logic             out_bit
`endif
);

  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    next_word = word;
    case (mode)
      SLL:     next_word = {word[WIDTH-2:0], 1'b0};
      SRL:     next_word = {1'b0, word[WIDTH-1:1]};
      SRA:     next_word = {word[WIDTH-1], word[WIDTH-1:1]};
      ROL:     next_word = {word[WIDTH-2:0], word[WIDTH-1]};
      default: next_word = word;
    endcase
  end

`ifdef SHIFT_CARRY_EN
  assign out_bit = is_left(mode) ? word[WIDTH-1] : word[0];
`endif

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: one bit position per clock, Start/Busy/Done handshake.
// Define SHIFT_CARRY_EN to add the registered carry_out (last bit shifted out).
module seq_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  seq_shifter_if.slave  bus
);

  localparam int SHW = $clog2(WIDTH);

  shift_state_t     state, state_nxt;
  logic [SHW-1:0]   count;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] result_q;
  shift_mode_t      mode_q;
  logic [WIDTH-1:0] step_word;
  logic             accept;
  logic             last_step;

  // A new request is taken from IDLE or straight out of DONE for back-to-back work.
  assign accept    = bus.start && (state == IDLE || state == DONE);
  assign last_step = (state == RUN) && (count == SHW'(1));

`ifdef SHIFT_CARRY_EN
  logic carry_q;
  logic step_bit;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .word      (work),
    .mode      (mode_q),
    .next_word (step_word),
    .out_bit   (step_bit)
  );
`else
  shift_step #(.WIDTH(WIDTH)) u_step (
    .word      (work),
    .mode      (mode_q),
    .next_word (step_word)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (bus.start) state_nxt = (bus.shamt == '0) ? DONE : RUN;
        else           state_nxt = IDLE;
      end
      RUN:     if (count == SHW'(1)) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every flop sample pre-edge values regardless of statement order.
    if (reset) begin
      work     <= '0;
      count    <= '0;
      result_q <= '0;
      mode_q   <= SLL;
    end else if (accept) begin
      work   <= bus.source;
      count  <= bus.shamt;
      mode_q <= bus.mode;
      if (bus.shamt == '0) result_q <= bus.source;
    end else if (state == RUN) begin
      work  <= step_word;
      count <= count - SHW'(1);
      if (last_step) result_q <= step_word;
    end
  end

`ifdef SHIFT_CARRY_EN
  // Cleared on accept so a zero-length shift reports no carry.
  always_ff @(posedge clk) begin
    if (reset)              carry_q <= 1'b0;
    else if (accept)        carry_q <= 1'b0;
    else if (state == RUN)  carry_q <= step_bit;
  end

  assign bus.carry_out = carry_q;
`endif

  // Busy/Done decode the state register only, so nothing reaches them from the inputs combinationally.
  assign bus.result = result_q;
  assign bus.busy   = (state == RUN);
  assign bus.done   = (state == DONE);

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter (WIDTH=8): directed scenarios then randomized operations.
// Carry checks are compiled in only when SHIFT_CARRY_EN is defined.
module tb_seq_shifter;
  import shift_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  logic [W-1:0] held = '0;

  always #5 clk = ~clk;

  seq_shifter_if #(.WIDTH(W)) bus ();

  seq_shifter #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word arithmetic over n positions at once.
  function automatic logic [W-1:0] model_res(input logic [W-1:0] s, input shift_mode_t m, input int n);
    logic signed [W-1:0] ss;
    ss = s;
    case (m)
      SLL:     return s << n;
      SRL:     return s >> n;
      SRA:     return ss >>> n;
      default: return (s << n) | (s >> (W - n));
    endcase
  endfunction

  function automatic logic model_carry(input logic [W-1:0] s, input shift_mode_t m, input int n);
    logic [W-1:0] r;
    if (n == 0) return 1'b0;
    r = model_res(s, m, n);
    case (m)
      SLL:     return s[W-n];
      SRL:     return s[n-1];
      SRA:     return s[n-1];
      default: return r[0];
    endcase
  endfunction

  // Drives Start now; checks every cycle up to and including the Done cycle, then returns inside it.
  task automatic run_op(input logic [W-1:0] src, input shift_mode_t m, input int n, input int poke_at);
    logic [W-1:0] er;
    logic         ec;
    er = model_res(src, m, n);
    ec = model_carry(src, m, n);
    bus.start  = 1'b1;
    bus.source = src;
    bus.mode   = m;
    bus.shamt  = n[2:0];
    for (int k = 1; k <= n + 1; k++) begin
      @(posedge clk); #1;
      bus.start  = 1'b0;
      bus.source = W'($urandom);
      bus.mode   = shift_mode_t'(2'($urandom_range(0, 3)));
      bus.shamt  = 3'($urandom);
      if (k == poke_at) begin
        bus.start  = 1'b1;
        bus.source = ~src;
      end
      check("busy", bus.busy, k <= n);
      check("done", bus.done, k == n + 1);
      if (k <= n) check("result_hold", bus.result, held);
`ifdef SHIFT_CARRY_EN
      if (k == 1 && n > 0) check("carry_clear", bus.carry_out, 1'b0);
`endif
    end
    check("result", bus.result, er);
`ifdef SHIFT_CARRY_EN
    check("carry", bus.carry_out, ec);
`endif
    held = er;
  endtask

  task automatic idle(input int cycles);
    bus.start = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      check("idle_done", bus.done, 1'b0);
      check("idle_busy", bus.busy, 1'b0);
      check("idle_result", bus.result, held);
    end
  endtask

  initial begin
    // Reset held together with Start: reset must win.
    reset      = 1'b1;
    bus.start  = 1'b1;
    bus.source = 8'hFF;
    bus.mode   = SLL;
    bus.shamt  = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", bus.result, 8'h00);
    check("rst_done", bus.done, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
`ifdef SHIFT_CARRY_EN
    check("rst_carry", bus.carry_out, 1'b0);
`endif
    bus.start = 1'b0;
    reset     = 1'b0;
    idle(2);

    // Directed cases with literal expectations.
    run_op(8'hB5, SLL, 3, 0);
    check("sll_b5", bus.result, 8'hA8);
`ifdef SHIFT_CARRY_EN
    check("sll_b5_c", bus.carry_out, 1'b1);
`endif
    idle(1);
    run_op(8'h90, SRA, 2, 0);
    check("sra_90", bus.result, 8'hE4);
    idle(1);
    run_op(8'h80, SRL, 7, 0);
    check("srl_80", bus.result, 8'h01);
    idle(1);
    run_op(8'h81, ROL, 1, 0);
    check("rol_81", bus.result, 8'h03);
`ifdef SHIFT_CARRY_EN
    check("rol_81_c", bus.carry_out, 1'b1);
`endif
    idle(1);
    run_op(8'h5A, SRA, 0, 0);
    check("zero_shamt", bus.result, 8'h5A);
    idle(1);

    // Start pulsed mid-RUN is ignored; then back-to-back from the Done cycle.
    run_op(8'hC3, SRL, 5, 2);
    run_op(8'h01, SLL, 2, 0);
    check("b2b_sll", bus.result, 8'h04);
    idle(2);

    // Reset during the second RUN cycle discards the operation.
    bus.start  = 1'b1;
    bus.source = 8'hFF;
    bus.mode   = SLL;
    bus.shamt  = 3'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_result", bus.result, 8'h00);
    check("midrst_done", bus.done, 1'b0);
    check("midrst_busy", bus.busy, 1'b0);
`ifdef SHIFT_CARRY_EN
    check("midrst_carry", bus.carry_out, 1'b0);
`endif
    held = '0;
    idle(9);
    run_op(8'h3C, ROL, 4, 0);
    idle(1);

    // Randomized operations with random gaps (0 = back-to-back).
    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), shift_mode_t'(2'($urandom_range(0, 3))),
             int'($urandom_range(0, W - 1)), 0);
      idle(int'($urandom_range(0, 2)));
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_shifter.md
# seq_shifter

- Parametrised, multi-cycle shift unit that succeeds the single-bit combinational shifter in the datapath.
- Shifts a WIDTH-bit operand by 0..WIDTH-1 positions, one bit position per clock.
- Supports four modes and uses a Start/Busy/Done handshake.
- Sits beside the ALU; the controller stalls on Busy and writes Result back on Done.

## Interface
- WIDTH, 8, operand width; power of two, ≥ 2.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request; sampled only when accepting (see Operation).
- Source  input  WIDTH  operand, captured on accepting edge.
- Mode  input  2  shift_mode_t, captured on accepting edge.
- Shamt  input  SHW  shift amount, captured on accepting edge.
- Result  output  WIDTH  shifted value; valid while Done, held until next accept.
- Done  output  1  one-cycle completion pulse.
- Busy  output  1  high while in RUN.
- CarryOut  output  1  last bit shifted out; present only with SHIFT_CARRY_EN.

## Operation
- Mode encoding:
  - 2'b00 SLL: logical left, zero fill.
  - 2'b01 SRL: logical right, zero fill.
  - 2'b10 SRA: arithmetic right, MSB replicated.
  - 2'b11 ROL: rotate left.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Start=1: capture Source into working register, Mode, and count=Shamt; clear CarryOut.
  - Next state is DONE if Shamt=0, else RUN.
- RUN, each cycle:
  - Working register takes one step in the captured mode; count decrements.
  - CarryOut takes the bit leaving the register: bit WIDTH-1 for SLL/ROL, bit 0 for SRL/SRA.
  - When count=1 before the decrement, next state is DONE.
- DONE:
  - Done=1 and Result = working register.
  - Start=1: accept as in IDLE, giving back-to-back operation.
  - Otherwise go to IDLE.
- Start in RUN is ignored; no queueing.
- Mode/Source/Shamt changes after capture have no effect.
- Result and CarryOut hold their last value in IDLE, and in RUN until overwritten.
- Reset (any state, including mid-RUN):
  - State=IDLE, working register=0, count=0.
  - Result=0, Done=0, Busy=0, CarryOut=0.
  - In-flight operation discarded; no Done issued.
- Reset and Start in the same cycle: Reset wins.

## Timing
- Start high in cycle c and accepted: Done high in cycle c+Shamt+1 exactly.
- Shamt=0 gives Done in c+1 with Result=Source.
- Busy high in cycles c+1 .. c+Shamt; low otherwise.
- Done high for exactly one cycle per accepted Start.
- Busy and Done are never both high.
- Back-to-back: Start high during Done cycle d gives the next Done at d+Shamt'+1; no idle bubble.
- Throughput: one operation per Shamt+1 cycles.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- SHIFT_CARRY_EN defined:
  - CarryOut port exists and is registered as above.
  - CarryOut=0 when Shamt=0.
  - For ROL, CarryOut equals Result[0].
- SHIFT_CARRY_EN undefined:
  - CarryOut port and its flop are absent.
  - All other behaviour and timing are identical.

## Structure
- Package shift_pkg holds:
  - shift_mode_t enum (SLL, SRL, SRA, ROL; 2 bits).
  - shift_state_t enum (IDLE, RUN, DONE).
- Sub-module shift_step: combinational single-position shift of WIDTH bits by mode.
  - Outputs the next word and the outgoing bit.
  - Instantiated once, fed by the working register.
- Top holds FSM, count register, working register, and carry flop.

## Test plan
WIDTH=8, SHIFT_CARRY_EN defined unless noted.
1. SLL, Source=8'hB5, Shamt=3, Start in cycle c -> Busy c+1..c+3, Done in c+4, Result=8'hA8, CarryOut=1.
2. SRA, Source=8'h90, Shamt=2 -> Done in c+3, Result=8'hE4, CarryOut=0. SRL, Source=8'h80, Shamt=7 -> Done in c+8, Result=8'h01, CarryOut=0.
3. ROL, Source=8'h81, Shamt=1 -> Result=8'h03, CarryOut=1. Shamt=0 with any mode, Source=8'h5A -> Done in c+1, Result=8'h5A, CarryOut=0, Busy never high.
4. Start pulsed mid-RUN with different Source -> ignored; single Done with original result. Start during Done cycle (SLL 8'h01, Shamt=2) -> second Done 3 cycles later, Result=8'h04.
5. Reset asserted in 2nd RUN cycle of SLL 8'hFF, Shamt=7 -> next cycle all outputs 0, state IDLE, no Done. Subsequent Start works normally.
6. Build without SHIFT_CARRY_EN and rerun scenarios 1-3 -> identical Result/Done/Busy timing; no CarryOut port.
